// File: rtl/quick_sort.sv
`default_nettype none
// ============================================================================
// quick_sort / quick_sort_reg_file : in-place iterative Lomuto quicksort over
// an internal register file.                                    Rev 1.0
// ============================================================================

module quick_sort_reg_file #(
  parameter int WORD_SIZE = 16,
  parameter int DEPTH     = 64
) (
  input  logic                 clk,
  input  logic [WORD_SIZE-1:0] i_raddr_a,
  input  logic [WORD_SIZE-1:0] i_raddr_b,
  output logic [WORD_SIZE-1:0] o_rdata_a,
  output logic [WORD_SIZE-1:0] o_rdata_b,
  input  logic                 i_we0,
  input  logic [WORD_SIZE-1:0] i_waddr0,
  input  logic [WORD_SIZE-1:0] i_wdata0,
  input  logic                 i_we1,
  input  logic [WORD_SIZE-1:0] i_waddr1,
  input  logic [WORD_SIZE-1:0] i_wdata1
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [WORD_SIZE-1:0] c_depth = WORD_SIZE'(DEPTH);

  logic [WORD_SIZE-1:0] REG_FILE [DEPTH];

  // Out-of-range addresses read as zero and never write.
  assign o_rdata_a = (i_raddr_a < c_depth) ? REG_FILE[i_raddr_a[AW-1:0]] : '0;
  assign o_rdata_b = (i_raddr_b < c_depth) ? REG_FILE[i_raddr_b[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (i_we0 && (i_waddr0 < c_depth)) REG_FILE[i_waddr0[AW-1:0]] <= i_wdata0;
    if (i_we1 && (i_waddr1 < c_depth)) REG_FILE[i_waddr1[AW-1:0]] <= i_wdata1;
  end
endmodule

module quick_sort #(
  parameter int WORD_SIZE = 16,
  parameter int DEPTH     = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WORD_SIZE-1:0] A,
  input  logic [WORD_SIZE-1:0] lo,
  input  logic [WORD_SIZE-1:0] hi,
  output logic                 done
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [WORD_SIZE-1:0] c_one     = 1;
  localparam logic [AW-1:0]        c_idx_one = 1;
  localparam logic [AW:0]          c_sp_one  = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_INIT, S_SCAN, S_PIVSWAP, S_PUSH, S_DONE
  } state_t;

  state_t               state, state_nxt;
  logic                 flag;
  logic [WORD_SIZE-1:0] pivot, i, j, lo_reg, hi_reg, r_base;
  logic [AW:0]          stack_pointer;
  logic [WORD_SIZE-1:0] stk_lo [DEPTH];
  logic [WORD_SIZE-1:0] stk_hi [DEPTH];

  logic [WORD_SIZE-1:0] w_addr_a, w_addr_b, w_rdata_a, w_rdata_b;
  logic                 w_lt, w_swap, w_push_left, w_push_right;
  logic [AW-1:0]        w_sp_idx, w_top_idx, w_right_idx;
  logic [AW:0]          w_push_cnt;

  // Port A addresses mem[hi_reg] while fetching/placing the pivot, else mem[j].
  assign w_addr_a = r_base + (((state == S_INIT) || (state == S_PIVSWAP)) ? hi_reg : j);
  assign w_addr_b = r_base + i;
  assign w_lt     = w_rdata_a < pivot;
  assign w_swap   = ((state == S_SCAN) && w_lt) || (state == S_PIVSWAP);

  assign w_push_left  = (lo_reg + c_one) < i;
  assign w_push_right = (i + c_one) < hi_reg;
  assign w_push_cnt   = {{AW{1'b0}}, w_push_left} + {{AW{1'b0}}, w_push_right};
  assign w_sp_idx     = stack_pointer[AW-1:0];
  assign w_top_idx    = w_sp_idx - c_idx_one;
  assign w_right_idx  = w_push_left ? (w_sp_idx + c_idx_one) : w_sp_idx;

  quick_sort_reg_file #(.WORD_SIZE(WORD_SIZE), .DEPTH(DEPTH)) reg_file (
    .clk      (clk),
    .i_raddr_a(w_addr_a),
    .i_raddr_b(w_addr_b),
    .o_rdata_a(w_rdata_a),
    .o_rdata_b(w_rdata_b),
    .i_we0    (w_swap),
    .i_waddr0 (w_addr_b),
    .i_wdata0 (w_rdata_a),
    .i_we1    (w_swap),
    .i_waddr1 (w_addr_a),
    .i_wdata1 (w_rdata_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (!flag) state_nxt = (lo < hi) ? S_POP : S_DONE;
      S_POP:     state_nxt = (stack_pointer == '0) ? S_DONE : S_INIT;
      S_INIT:    state_nxt = S_SCAN;
      S_SCAN:    if (j == (hi_reg - c_one)) state_nxt = S_PIVSWAP;
      S_PIVSWAP: state_nxt = S_PUSH;
      S_PUSH:    state_nxt = S_POP;
      S_DONE:    if (!flag) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag          <= 1'b0;
      stack_pointer <= '0;
      pivot         <= '0;
      i             <= '0;
      j             <= '0;
      lo_reg        <= '0;
      hi_reg        <= '0;
      r_base        <= '0;
    end else begin
      case (state)
        S_IDLE: if (!flag) begin
          lo_reg <= lo;
          hi_reg <= hi;
          r_base <= A;
          flag   <= 1'b1;
          if (lo < hi) stack_pointer <= stack_pointer + c_sp_one;
        end
        S_POP: if (stack_pointer != '0) begin
          lo_reg        <= stk_lo[w_top_idx];
          hi_reg        <= stk_hi[w_top_idx];
          stack_pointer <= stack_pointer - c_sp_one;
        end
        S_INIT: begin
          pivot <= w_rdata_a;
          i     <= lo_reg;
          j     <= lo_reg;
        end
        S_SCAN: begin
          if (w_lt) i <= i + c_one;
          j <= j + c_one;
        end
        S_PUSH:  stack_pointer <= stack_pointer + w_push_cnt;
        default: ;
      endcase
    end
  end

  // Stack storage carries no reset; stack_pointer alone defines validity.
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && !flag && (lo < hi)) begin
      stk_lo[w_sp_idx] <= lo;
      stk_hi[w_sp_idx] <= hi;
    end
    if (state == S_PUSH) begin
      if (w_push_left) begin
        stk_lo[w_sp_idx] <= lo_reg;
        stk_hi[w_sp_idx] <= i - c_one;
      end
      if (w_push_right) begin
        stk_lo[w_right_idx] <= i + c_one;
        stk_hi[w_right_idx] <= hi_reg;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_quick_sort.sv
`default_nettype none
// ============================================================================
// tb_quick_sort : randomized and directed checks of quick_sort against an
// insertion-sort reference model.                               Rev 1.0
// ============================================================================
module tb_quick_sort;
  localparam int W = 16;
  localparam int D = 64;
  typedef logic [W-1:0] wq_t[$];

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] A = '0, lo = '0, hi = '0;
  logic         done;
  int           checks = 0;
  int           passed = 0;
  logic [W-1:0] mem_model [D];

  quick_sort #(.WORD_SIZE(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .lo(lo), .hi(hi), .done(done)
  );

  always #5 clk = ~clk;

  function automatic wq_t sorted(wq_t q);
    wq_t r = q;
    for (int a = 1; a < r.size(); a++) begin
      logic [W-1:0] key = r[a];
      int b = a - 1;
      while (b >= 0 && r[b] > key) begin
        r[b+1] = r[b];
        b--;
      end
      r[b+1] = key;
    end
    return r;
  endfunction

  task automatic model_sort(input int base, input int l, input int h);
    wq_t q;
    for (int k = l; k <= h; k++) q.push_back(mem_model[base+k]);
    q = sorted(q);
    for (int k = l; k <= h; k++) mem_model[base+k] = q[k-l];
  endtask

  task automatic fill_background();
    for (int k = 0; k < D; k++) mem_model[k] = W'($urandom);
  endtask

  task automatic begin_sort(input int a, input int l, input int h);
    @(negedge clk);
    rst_n = 1'b0;
    A = W'(a); lo = W'(l); hi = W'(h);
    for (int k = 0; k < D; k++) dut.reg_file.REG_FILE[k] = mem_model[k];
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_sp(input bit want_nonzero, output bit ok);
    int n = 0;
    while (((dut.stack_pointer != 0) != want_nonzero) && n < 500) begin
      @(negedge clk);
      n++;
    end
    ok = ((dut.stack_pointer != 0) == want_nonzero);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    checks++; if (dut.flag !== 1'b0) $display("FAIL reset_flag got %b want 0", dut.flag); else passed++;
    checks++; if (dut.stack_pointer !== 0) $display("FAIL reset_sp got %0d want 0", dut.stack_pointer); else passed++;
    checks++;
    if ({dut.pivot, dut.i, dut.j, dut.lo_reg, dut.hi_reg} !== '0)
      $display("FAIL reset_regs got %h want 0", {dut.pivot, dut.i, dut.j, dut.lo_reg, dut.hi_reg});
    else passed++;
    dut.reg_file.REG_FILE[7] = 16'hBEEF;
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.reg_file.REG_FILE[7] !== 16'hBEEF)
      $display("FAIL reset_keeps_mem got %h want beef", dut.reg_file.REG_FILE[7]);
    else passed++;
  endtask

  task automatic test_spec_example();
    logic [W-1:0] init_v [10] = '{55, 8, 34, 6, 5, 22, 33, 2, 1, 13};
    logic [W-1:0] part_v [10] = '{8, 6, 5, 2, 1, 13, 33, 55, 34, 22};
    bit ok;
    int cyc;
    fill_background();
    for (int k = 0; k < 10; k++) mem_model[k] = init_v[k];
    begin_sort(0, 0, 9);
    wait_sp(1'b1, ok);
    if (ok) wait_sp(1'b0, ok);
    if (ok) wait_sp(1'b1, ok);  // first PUSH done; memory holds the post-PIVSWAP image
    checks++; if (!ok) $display("FAIL ex_first_push timeout got 0 want 1"); else passed++;
    checks++; if (dut.pivot !== 13) $display("FAIL ex_pivot got %0d want 13", dut.pivot); else passed++;
    checks++; if (dut.i !== 5) $display("FAIL ex_i got %0d want 5", dut.i); else passed++;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (dut.reg_file.REG_FILE[k] !== part_v[k])
        $display("FAIL ex_partition word %0d got %0d want %0d", k, dut.reg_file.REG_FILE[k], part_v[k]);
      else passed++;
    end
    wait_done(cyc);
    checks++; if (done !== 1'b1) $display("FAIL ex_done got %b want 1", done); else passed++;
    checks++; if (dut.stack_pointer !== 0) $display("FAIL ex_sp got %0d want 0", dut.stack_pointer); else passed++;
    model_sort(0, 0, 9);
    for (int k = 0; k < D; k++) begin
      checks++;
      if (dut.reg_file.REG_FILE[k] !== mem_model[k])
        $display("FAIL ex_final word %0d got %0d want %0d", k, dut.reg_file.REG_FILE[k], mem_model[k]);
      else passed++;
    end
  endtask

  task automatic test_sorted();
    bit ok;
    int n, c, max_sp;
    fill_background();
    for (int k = 0; k < 10; k++) mem_model[k] = W'(k + 1);
    begin_sort(0, 0, 9);
    wait_sp(1'b1, ok);
    if (ok) wait_sp(1'b0, ok);
    n = 0;
    while (ok && dut.stack_pointer == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    // POP cycle plus the INIT..PUSH cycles until the next push lands
    checks++; if (1 + n !== 13) $display("FAIL sorted_partition_cycles got %0d want 13", 1 + n); else passed++;
    max_sp = dut.stack_pointer;
    c = 0;
    while (done !== 1'b1 && c < 5000) begin
      @(negedge clk);
      c++;
      if (dut.stack_pointer > max_sp) max_sp = dut.stack_pointer;
    end
    checks++; if (done !== 1'b1) $display("FAIL sorted_done got %b want 1", done); else passed++;
    checks++; if (max_sp !== 1) $display("FAIL sorted_max_sp got %0d want 1", max_sp); else passed++;
    for (int k = 0; k < D; k++) begin
      checks++;
      if (dut.reg_file.REG_FILE[k] !== mem_model[k])
        $display("FAIL sorted_final word %0d got %0d want %0d", k, dut.reg_file.REG_FILE[k], mem_model[k]);
      else passed++;
    end
  endtask

  task automatic test_window(input string name, input int base, input int l, input int h);
    int cyc;
    begin_sort(base, l, h);
    wait_done(cyc);
    checks++; if (done !== 1'b1) $display("FAIL %s_done got %b want 1", name, done); else passed++;
    model_sort(base, l, h);
    for (int k = 0; k < D; k++) begin
      checks++;
      if (dut.reg_file.REG_FILE[k] !== mem_model[k])
        $display("FAIL %s word %0d got %0d want %0d", name, k, dut.reg_file.REG_FILE[k], mem_model[k]);
      else passed++;
    end
  endtask

  task automatic test_duplicates();
    logic [W-1:0] v [5] = '{7, 3, 7, 3, 7};
    fill_background();
    for (int k = 0; k < 5; k++) mem_model[k] = v[k];
    test_window("dup", 0, 0, 4);
  endtask

  task automatic test_offset_window();
    logic [W-1:0] v [4] = '{9, 4, 8, 1};
    fill_background();
    for (int k = 0; k < 4; k++) mem_model[22+k] = v[k];
    test_window("offset", 20, 2, 5);
  endtask

  task automatic test_single();
    fill_background();
    begin_sort(0, 3, 3);
    checks++; if (done !== 1'b0) $display("FAIL single_early got %b want 0", done); else passed++;
    repeat (2) @(negedge clk);
    checks++; if (done !== 1'b1) $display("FAIL single_done got %b want 1", done); else passed++;
    for (int k = 0; k < D; k++) begin
      checks++;
      if (dut.reg_file.REG_FILE[k] !== mem_model[k])
        $display("FAIL single word %0d got %0d want %0d", k, dut.reg_file.REG_FILE[k], mem_model[k]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_sort();
    logic [W-1:0] init_v [10] = '{55, 8, 34, 6, 5, 22, 33, 2, 1, 13};
    wq_t got, want;
    int cyc;
    fill_background();
    for (int k = 0; k < 10; k++) mem_model[k] = init_v[k];
    begin_sort(0, 0, 9);
    repeat (6) @(negedge clk);  // IDLE, POP, INIT, then into SCAN
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dut.flag !== 1'b0) $display("FAIL midrst_flag got %b want 0", dut.flag); else passed++;
    checks++; if (dut.stack_pointer !== 0) $display("FAIL midrst_sp got %0d want 0", dut.stack_pointer); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL midrst_done got %b want 0", done); else passed++;
    for (int k = 0; k < 10; k++) begin
      got.push_back(dut.reg_file.REG_FILE[k]);
      want.push_back(mem_model[k]);
    end
    got = sorted(got);
    want = sorted(want);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (got[k] !== want[k]) $display("FAIL midrst_multiset rank %0d got %0d want %0d", k, got[k], want[k]);
      else passed++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(cyc);
    checks++; if (done !== 1'b1) $display("FAIL midrst_resort_done got %b want 1", done); else passed++;
    model_sort(0, 0, 9);
    for (int k = 0; k < D; k++) begin
      checks++;
      if (dut.reg_file.REG_FILE[k] !== mem_model[k])
        $display("FAIL midrst_final word %0d got %0d want %0d", k, dut.reg_file.REG_FILE[k], mem_model[k]);
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      int n = $urandom_range(2, 16);
      int base = $urandom_range(0, 30);
      int l = $urandom_range(0, 8);
      bit narrow = t[0];
      fill_background();
      for (int k = l; k < l + n; k++)
        mem_model[base+k] = narrow ? W'($urandom_range(0, 7)) : W'($urandom);
      test_window("random", base, l, l + n - 1);
    end
  endtask

  initial begin
    test_reset();
    test_spec_example();
    test_sorted();
    test_duplicates();
    test_offset_window();
    test_single();
    test_reset_mid_sort();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
`default_nettype wire
